// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write path.
package rf_pkg;

  localparam int RF_AW    = 4;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 1 << RF_AW;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  // Fixed requester slots on the write port.
  localparam int REQ_LOAD = 0;
  localparam int REQ_DIV  = 1;
  localparam int REQ_WB   = 2;
  localparam int RF_NREQ  = 3;

endpackage

// File: rtl/rf_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant plus encoded winner index.
// Shared by the write arbiter and future read-port schedulers.
module rr_pick
  import rf_pkg::*;
#(
  parameter int N  = RF_NREQ,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk the requests starting at ptr, wrapping, and grant the first one seen.
  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// registered write stage and a "written since clear" scoreboard.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  hold,
  input  logic                  sb_clr,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_wa,
  output logic [DW-1:0]         rf_wd,
  output logic [(1<<AW)-1:0]    sb_valid,
  output logic [GW-1:0]         last_gnt,
  output logic                  busy
);

  localparam int DEPTH = 1 << AW;

  logic [GW-1:0]    ptr;
  logic [GW-1:0]    ptr_next;
  logic [GW-1:0]    pick_idx;
  logic [NREQ-1:0]  pick_gnt;
  logic             pick_found;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic [DEPTH-1:0] sb_next;

  // Granting is suppressed during hold and while reset is asserted, so ready
  // drops immediately with rst_n rather than waiting for a clock.
  rr_pick #(
    .N  (NREQ),
    .IW (GW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (~hold & rst_n),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign req_ready = pick_gnt;
  assign busy      = rf_we | (|req_valid);

  // Steer the winner's address/data to the write stage and compute the next pointer.
  always_comb begin
    sel_addr = req_addr[int'(pick_idx)*AW +: AW];
    sel_data = req_data[int'(pick_idx)*DW +: DW];
    if (int'(pick_idx) == NREQ - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = pick_idx + GW'(1);
    end
  end

  // Register the accepted write; address/data hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      last_gnt <= '0;
      ptr      <= '0;
    end else begin
      rf_we <= pick_found;
      if (pick_found) begin
        rf_wa    <= sel_addr;
        rf_wd    <= sel_data;
        last_gnt <= pick_idx;
        ptr      <= ptr_next;
      end
    end
  end

  // A clear and a write in the same cycle leave only the written bit set.
  always_comb begin
    sb_next = sb_clr ? '0 : sb_valid;
    if (rf_we) begin
      sb_next[rf_wa] = 1'b1;
    end
  end

  // Scoreboard bits update on the same edge the register file takes the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
    end else begin
      sb_valid <= sb_next;
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios followed by a
// randomized run, all compared against a simple behavioural model.
module tb_rf_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int GW   = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 hold;
  logic                 sb_clr;
  logic                 rf_we;
  logic [AW-1:0]        rf_wa;
  logic [DW-1:0]        rf_wd;
  logic [15:0]          sb_valid;
  logic [GW-1:0]        last_gnt;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  // requester drivers and the previous-cycle snapshot for protocol checking
  logic [2:0]  rv;
  logic [3:0]  ra [3];
  logic [31:0] rd [3];
  logic [2:0]  pv;
  logic [3:0]  pa [3];
  logic [31:0] pd [3];
  int          pidx;

  // behavioural model state
  int          m_ptr;
  int          m_last;
  logic        m_we;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_sb [16];
  logic [31:0] m_mem [16];
  logic [31:0] obs_mem [16];
  int          last_acc;

  rf_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .sb_clr    (sb_clr),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .sb_valid  (sb_valid),
    .last_gnt  (last_gnt),
    .busy      (busy)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first valid requester at or after p, wrapping; -1 when nobody asks
  function automatic int pickModel(input logic [2:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] sbModel();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = m_sb[k];
    return r;
  endfunction

  task automatic refill(input int i);
    ra[i] = 4'($urandom_range(0, 15));
    rd[i] = $urandom;
  endtask

  // One clock cycle: drive, check grant, clock, advance model, check outputs.
  task automatic applyStimulus(input logic h, input logic clr);
    int g;
    logic [2:0] exp_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (pv[i] && pidx != i) begin
        assert (rv[i] && ra[i] == pa[i] && rd[i] == pd[i])
          else $error("[TB] requester %0d broke its pending request", i);
      end
    end
    hold      = h;
    sb_clr    = clr;
    req_valid = rv;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
    #1;
    g = h ? -1 : pickModel(rv, m_ptr);
    exp_ready = 3'b000;
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("busy", busy, m_we | (|rv));
    if (rf_we) obs_mem[rf_wa] = rf_wd;
    @(posedge clk);
    if (clr) for (int k = 0; k < 16; k++) m_sb[k] = 1'b0;
    if (m_we) begin
      m_sb[m_wa]  = 1'b1;
      m_mem[m_wa] = m_wd;
    end
    pv = rv;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = ra[i];
      pd[i] = rd[i];
    end
    pidx = g;
    if (g >= 0) begin
      m_we   = 1'b1;
      m_wa   = ra[g];
      m_wd   = rd[g];
      m_last = g;
      m_ptr  = (g + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    last_acc = g;
    #1;
    checkOutput("rf_we", rf_we, m_we);
    checkOutput("rf_wa", rf_wa, m_wa);
    checkOutput("rf_wd", rf_wd, m_wd);
    checkOutput("last_gnt", last_gnt, m_last);
    checkOutput("sb_valid", sb_valid, sbModel());
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge arrives.
  task automatic resetDut();
    req_valid = rv;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we", rf_we, 1'b0);
    checkOutput("rst_wa", rf_wa, 4'h0);
    checkOutput("rst_wd", rf_wd, 32'h0);
    checkOutput("rst_sb", sb_valid, 16'h0000);
    checkOutput("rst_last", last_gnt, 2'd0);
    checkOutput("rst_ready", req_ready, 3'b000);
    m_ptr = 0; m_last = 0; m_we = 1'b0; m_wa = 4'h0; m_wd = 32'h0;
    for (int k = 0; k < 16; k++) m_sb[k] = 1'b0;
    rv = 3'b000; req_valid = 3'b000; pv = 3'b000; pidx = -1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Retire every pending request, then one idle cycle to flush the write stage.
  task automatic drainReqs();
    for (int n = 0; n < 8 && rv != 3'b000; n++) begin
      applyStimulus(1'b0, 1'b0);
      if (last_acc >= 0) rv[last_acc] = 1'b0;
    end
    checkOutput("drain_empty", rv, 3'b000);
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; hold = 1'b0; sb_clr = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    rv = 3'b111; pv = 3'b000; pidx = -1; last_acc = -1;
    for (int i = 0; i < NREQ; i++) begin ra[i] = 4'h0; rd[i] = 32'h0; end
    for (int k = 0; k < 16; k++) begin m_mem[k] = 32'h0; obs_mem[k] = 32'h0; end
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1;
    resetDut();

    // single write from requester 1
    rv = 3'b010; ra[1] = 4'h5; rd[1] = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_we", rf_we, 1'b1);
    checkOutput("single_wa", rf_wa, 4'h5);
    checkOutput("single_wd", rf_wd, 32'hDEAD_BEEF);
    checkOutput("single_last", last_gnt, 2'd1);
    rv = 3'b000;
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_sb", sb_valid, 16'h0020);

    // reset while a write is in flight
    rv = 3'b111;
    for (int i = 0; i < NREQ; i++) refill(i);
    applyStimulus(1'b0, 1'b0);
    checkOutput("midrst_pending", rf_we, 1'b1);
    resetDut();
    applyStimulus(1'b0, 1'b0);
    checkOutput("midrst_dropped", rf_we, 1'b0);

    // all three contending: strict rotation from requester 0
    rv = 3'b111;
    for (int i = 0; i < NREQ; i++) refill(i);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("contention_order", last_gnt, c % 3);
      checkOutput("contention_we", rf_we, 1'b1);
      if (last_acc >= 0) refill(last_acc);
    end

    // hold freezes granting; resumes at the frozen pointer
    applyStimulus(1'b0, 1'b0);
    if (last_acc >= 0) refill(last_acc);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("hold_we", rf_we, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold_resume", last_gnt, 2'd1);
    if (last_acc >= 0) refill(last_acc);
    drainReqs();

    // scoreboard collision: clear and write in the same cycle
    applyStimulus(1'b0, 1'b1);
    checkOutput("sb_cleared", sb_valid, 16'h0000);
    for (int k = 0; k < 9; k++) begin
      rv = 3'b001;
      ra[0] = (k < 8) ? 4'(k) : 4'hA;
      rd[0] = $urandom;
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("sb_ff", sb_valid, 16'h00FF);
    rv = 3'b000;
    applyStimulus(1'b0, 1'b1);
    checkOutput("sb_collide", sb_valid, 16'h0400);

    // same address from requesters 0 and 2 (pointer sits at 1, so 2 goes first)
    rv = 3'b101;
    ra[0] = 4'h3; rd[0] = 32'd1;
    ra[2] = 4'h3; rd[2] = 32'd2;
    applyStimulus(1'b0, 1'b0);
    checkOutput("race_first", last_gnt, 2'd2);
    rv[2] = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("race_second", last_gnt, 2'd0);
    rv = 3'b000;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("race_rf", obs_mem[3], 32'd1);
    checkOutput("race_sb", sb_valid[3], 1'b1);

    // randomized traffic with sporadic hold and clear
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          refill(i);
        end
      end
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      if (last_acc >= 0) begin
        if ($urandom_range(0, 1) == 0) rv[last_acc] = 1'b0;
        else refill(last_acc);
      end
    end
    drainReqs();
    for (int k = 0; k < 16; k++) checkOutput("rf_content", obs_mem[k], m_mem[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
